local_port_in_buffer: RTL
=========================

Name: local_port_in_buffer

Overview:
- Local-port input buffer of a mesh router; sits directly downstream of a PE injector.
- Upstream side: accepts 32-bit packets through a request/grant handshake and reports a full flag back to the injector.
- Stores packets in a FIFO and re-issues them to the router crossbar arbiter through the same request/grant protocol.
- Packet format: {xDst[31:28], yDst[27:24], xSrc[23:20], ySrc[19:16], PacketID[15:6], ModuleID[5:0]}; the buffer does not modify packet contents.

Parameters:
- dataWidth, 32, packet width in bits.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ReqUpStr  input  1  injector request; held high until a grant is seen.
- PacketIn  input  dataWidth  injector packet; stable while ReqUpStr is high.
- GntUpStr  output  1  one-cycle grant to the injector.
- UpStrFull  output  1  buffer full indication to the injector.
- ReqDnStr  output  1  request to the crossbar arbiter.
- GntDnStr  input  1  grant from the arbiter.
- DnStrFull  input  1  target output-port buffer is full.
- PacketOut  output  dataWidth  head-of-FIFO packet.
- PktCount  output  16  accepted-packet statistic (optional feature).

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, rd_ptr/wr_ptr/count = 0, output FSM = IDLE, storage contents don't-care. Reset mid-transfer discards every stored packet; an in-flight grant is cancelled.
- Accept (upstream): at a rising edge where ReqUpStr=1, GntUpStr=0 and count<DEPTH:
  - write PacketIn at wr_ptr;
  - wr_ptr+1, wrapping modulo DEPTH;
  - GntUpStr<=1 for exactly one cycle.
- While GntUpStr=1, the still-high ReqUpStr is ignored; the injector drops it on the next edge. Maximum acceptance rate is 1 packet per 2 cycles.
- UpStrFull = (count==DEPTH). It is combinational from registered count and is 1 in the cycle after the DEPTH-th write.
- When full, ReqUpStr is ignored and GntUpStr stays 0; acceptance resumes on the first edge after count drops.
- PacketOut = storage[rd_ptr]. It is valid whenever count>0 and holds 0 only after reset while empty.
- Output FSM, 2-bit, encoded IDLE=00, SEND_REQ=01, WAIT_GRANT=10, RELEASE=11:
  - IDLE: count>0 -> SEND_REQ.
  - SEND_REQ: DnStrFull=0 -> ReqDnStr<=1, go to WAIT_GRANT; else stay.
  - WAIT_GRANT: GntDnStr=1 -> ReqDnStr<=0, rd_ptr+1 (wrap), count-1, go to RELEASE; else hold ReqDnStr and PacketOut, stay.
  - RELEASE: one idle cycle, then -> IDLE.
- GntDnStr is ignored in every state except WAIT_GRANT.
- Simultaneous write and pop in the same edge: count unchanged, both pointers advance.
- A pop while full and a pending ReqUpStr in the same edge: no grant this edge, because UpStrFull was 1 when sampled. The grant is issued on the next edge.
- Latency: packet accepted at edge k -> ReqDnStr high after edge k+2 at the earliest (empty buffer, DnStrFull=0).
- count is PTR_W+1 bits and never exceeds DEPTH or underflows.

Optional Feature:
- Macro LOCAL_BUF_STATS_EN.
- Defined: PktCount is a 16-bit register, cleared by reset, incremented on every accept; wraps 0xFFFF->0x0000.
- Undefined: PktCount is tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package noc_pkg:
  - dataWidth;
  - packet field bit positions (XDST_MSB … MODID_LSB);
  - 4-bit coordinate width dim;
  - output FSM state encodings.
- Sub-module noc_sync_fifo: storage array, pointers and count, full/empty, push/pop inputs.
- local_port_in_buffer keeps both handshake engines and the statistic.

Test Plan:
- Reset, then one req with PacketIn=0x2C000405 -> GntUpStr pulse 1 cycle; ReqDnStr=1 two edges later with PacketOut=0x2C000405; GntDnStr pulse -> ReqDnStr=0, buffer empty.
- Hold GntDnStr=0, inject 4 packets -> exactly 4 grants; UpStrFull=1; fifth req gets no grant until one GntDnStr pop, then granted on the following edge.
- DnStrFull=1 for 10 cycles with 1 packet stored -> ReqDnStr stays 0; on DnStrFull=0 -> ReqDnStr=1 next edge.
- Back-to-back push and pop with count=2 -> count stays 2; packets emerge in order, including across the pointer wrap 3->0 over 9 packets.
- Assert reset during WAIT_GRANT with 3 packets stored -> all outputs 0 immediately, UpStrFull=0; the first post-reset packet is output first.
- LOCAL_BUF_STATS_EN defined, 5 accepts -> PktCount=5; undefined -> PktCount=0 throughout.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the router local-port input path: packet layout,
// coordinate width and output-handshake FSM encodings.
package noc_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 32;
  localparam int unsigned DIM            = 4;

  localparam int unsigned XDST_MSB  = 31;
  localparam int unsigned XDST_LSB  = 28;
  localparam int unsigned YDST_MSB  = 27;
  localparam int unsigned YDST_LSB  = 24;
  localparam int unsigned XSRC_MSB  = 23;
  localparam int unsigned XSRC_LSB  = 20;
  localparam int unsigned YSRC_MSB  = 19;
  localparam int unsigned YSRC_LSB  = 16;
  localparam int unsigned PKTID_MSB = 15;
  localparam int unsigned PKTID_LSB = 6;
  localparam int unsigned MODID_MSB = 5;
  localparam int unsigned MODID_LSB = 0;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    SEND_REQ   = 2'b01,
    WAIT_GRANT = 2'b10,
    RELEASE    = 2'b11
  } out_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with occupancy count; push ignored when full, pop ignored
// when empty. Head entry is presented combinationally on data_o.
module noc_sync_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q];

  // Storage: cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/local_port_in_buffer.sv
// Local-port input buffer: injector-side grant engine, FIFO, and arbiter-side
// request FSM. Define LOCAL_BUF_STATS_EN to build the accepted-packet counter.
module local_port_in_buffer
  import noc_pkg::*;
#(
  parameter int unsigned dataWidth = NOC_DATA_WIDTH,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ReqUpStr,
  input  logic [dataWidth-1:0] PacketIn,
  output logic                 GntUpStr,
  output logic                 UpStrFull,
  output logic                 ReqDnStr,
  input  logic                 GntDnStr,
  input  logic                 DnStrFull,
  output logic [dataWidth-1:0] PacketOut,
  output logic [15:0]          PktCount
);
  out_state_e state_q, state_d;
  logic       gnt_up_q;
  logic       req_dn_q, req_dn_d;
  logic       accept_s;
  logic       pop_s;
  logic       full_s;
  logic       empty_s;

  noc_sync_fifo #(
    .DW    (dataWidth),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept_s),
    .data_i  (PacketIn),
    .pop_i   (pop_s),
    .data_o  (PacketOut),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // A grant cycle masks the injector's still-high request.
  assign accept_s  = ReqUpStr & ~gnt_up_q & ~full_s;
  assign GntUpStr  = gnt_up_q;
  assign UpStrFull = full_s;
  assign ReqDnStr  = req_dn_q;

  // Upstream grant pulse and downstream FSM state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_up_q <= 1'b0;
      req_dn_q <= 1'b0;
      state_q  <= IDLE;
    end else begin
      gnt_up_q <= accept_s;
      req_dn_q <= req_dn_d;
      state_q  <= state_d;
    end
  end

  // Downstream request/grant sequencing; GntDnStr only matters in WAIT_GRANT.
  always_comb begin
    state_d  = state_q;
    req_dn_d = req_dn_q;
    pop_s    = 1'b0;
    case (state_q)
      IDLE: begin
        req_dn_d = 1'b0;
        if (!empty_s) state_d = SEND_REQ;
        else          state_d = IDLE;
      end
      SEND_REQ: begin
        if (!DnStrFull) begin
          req_dn_d = 1'b1;
          state_d  = WAIT_GRANT;
        end else begin
          req_dn_d = 1'b0;
          state_d  = SEND_REQ;
        end
      end
      WAIT_GRANT: begin
        if (GntDnStr) begin
          req_dn_d = 1'b0;
          pop_s    = 1'b1;
          state_d  = RELEASE;
        end else begin
          req_dn_d = 1'b1;
          state_d  = WAIT_GRANT;
        end
      end
      RELEASE: begin
        req_dn_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        req_dn_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

`ifdef LOCAL_BUF_STATS_EN
  logic [15:0] pkt_cnt_q;

  // Accepted-packet statistic, wraps at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt_q <= 16'd0;
    end else if (accept_s) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end else begin
      pkt_cnt_q <= pkt_cnt_q;
    end
  end

  assign PktCount = pkt_cnt_q;
`else
  assign PktCount = 16'd0;
`endif

endmodule
